// File: rtl/uart_wb_arbiter.sv
// Two-master Wishbone classic arbiter in front of the UART slave.
// Master 0 is the xmodem receiver, master 1 the core-side console master.
// The slave is granted per bus cycle: the owner keeps it while its cyc is high.
// A stuck-slave timer ends a strobe that waits too long with a one-cycle err.
//
// Handshake: a transfer is offered while s_stb_o=1 and completes on the cycle
// s_ack_i=1 (classic Wishbone, no pipelining); err replaces ack on timeout.
module uart_wb_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                m0_cyc_i,
    input  logic                m0_stb_i,
    input  logic                m0_we_i,
    input  logic [ADDR_W-1:0]   m0_adr_i,
    input  logic [DATA_W-1:0]   m0_dat_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    output logic [DATA_W-1:0]   m0_dat_o,
    output logic                m0_ack_o,
    output logic                m0_err_o,
    input  logic                m1_cyc_i,
    input  logic                m1_stb_i,
    input  logic                m1_we_i,
    input  logic [ADDR_W-1:0]   m1_adr_i,
    input  logic [DATA_W-1:0]   m1_dat_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    output logic [DATA_W-1:0]   m1_dat_o,
    output logic                m1_ack_o,
    output logic                m1_err_o,
    output logic                s_cyc_o,
    output logic                s_stb_o,
    output logic                s_we_o,
    output logic [ADDR_W-1:0]   s_adr_o,
    output logic [DATA_W-1:0]   s_dat_o,
    output logic [DATA_W/8-1:0] s_sel_o,
    input  logic [DATA_W-1:0]   s_dat_i,
    input  logic                s_ack_i
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               last_grant_q, last_grant_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               err_q, err_d;

    logic               own0, own1;
    logic               waiting;

    // Output mux: slave follows the owner; everything is 0 while idle.
    always_comb begin
        own0     = (state_q == S_OWN0);
        own1     = (state_q == S_OWN1);
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        if (own0) begin
            s_cyc_o = m0_cyc_i;
            s_stb_o = m0_stb_i & ~err_q;
            s_we_o  = m0_we_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
        end else if (own1) begin
            s_cyc_o = m1_cyc_i;
            s_stb_o = m1_stb_i & ~err_q;
            s_we_o  = m1_we_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
        end
        // Strobe is on the bus but the slave has not answered yet.
        waiting  = s_stb_o & ~s_ack_i;
        m0_ack_o = own0 & s_ack_i;
        m1_ack_o = own1 & s_ack_i;
        m0_err_o = own0 & err_q;
        m1_err_o = own1 & err_q;
        m0_dat_o = own0 ? s_dat_i : '0;
        m1_dat_o = own1 ? s_dat_i : '0;
    end

    // Next state: round-robin grant from idle, cyc lock while owned, stuck-slave timer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        timer_d      = '0;
        err_d        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_grant_q ? S_OWN0 : S_OWN1;
                end else if (m0_cyc_i) begin
                    state_d = S_OWN0;
                end else if (m1_cyc_i) begin
                    state_d = S_OWN1;
                end
            end
            S_OWN0: begin
                if (!m0_cyc_i) begin
                    state_d      = S_IDLE;
                    last_grant_d = 1'b0;
                end
            end
            S_OWN1: begin
                if (!m1_cyc_i) begin
                    state_d      = S_IDLE;
                    last_grant_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // waiting is only ever true in an owned state; ack or stb low clears the timer.
        if (waiting) begin
            if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
                err_d = 1'b1;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            timer_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_uart_wb_arbiter.sv
// Directed bench for uart_wb_arbiter (TIMEOUT_CYC=8). Inputs change 2ns
// after each rising edge; outputs are checked 1ns after inputs settle.
module tb_uart_wb_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rstn;
    logic          m0_cyc_i, m0_stb_i, m0_we_i;
    logic [AW-1:0] m0_adr_i;
    logic [DW-1:0] m0_dat_i;
    logic [SW-1:0] m0_sel_i;
    logic [DW-1:0] m0_dat_o;
    logic          m0_ack_o, m0_err_o;
    logic          m1_cyc_i, m1_stb_i, m1_we_i;
    logic [AW-1:0] m1_adr_i;
    logic [DW-1:0] m1_dat_i;
    logic [SW-1:0] m1_sel_i;
    logic [DW-1:0] m1_dat_o;
    logic          m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [SW-1:0] s_sel_o;
    logic [DW-1:0] s_dat_i;
    logic          s_ack_i;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] rd_vals [3] = '{32'h11, 32'h22, 32'h33};

    // clock / reset
    always #5 clk = ~clk;

    uart_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rstn(rstn),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i)
    );

    // scoreboard check
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver helpers
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0;
        s_dat_i = '0; s_ack_i = 0;
        repeat (2) @(posedge clk);
        #2;

        // Reset: requests are not forwarded while reset is held.
        m0_cyc_i = 1; m0_stb_i = 1; m0_dat_i = 32'hdead; s_ack_i = 1;
        settle();
        check_eq("rst_s_cyc", s_cyc_o, 0);
        check_eq("rst_s_stb", s_stb_o, 0);
        check_eq("rst_s_dat", s_dat_o, 0);
        check_eq("rst_m0_ack", m0_ack_o, 0);
        m0_cyc_i = 0; m0_stb_i = 0; m0_dat_i = '0; s_ack_i = 0;
        rstn = 1'b1;
        tick();

        // Contest on the same edge: m0 first, turnaround, then m1.
        m0_cyc_i = 1; m0_adr_i = 8'h10; m1_cyc_i = 1; m1_adr_i = 8'h20;
        settle();
        check_eq("idle_no_cyc", s_cyc_o, 0);
        tick();
        check_eq("c1_cyc", s_cyc_o, 1);
        check_eq("c1_owner_m0", s_adr_o, 8'h10);
        m0_cyc_i = 0;
        tick();
        check_eq("turnaround", s_cyc_o, 0);
        tick();
        check_eq("c1_then_m1_cyc", s_cyc_o, 1);
        check_eq("c1_then_m1_adr", s_adr_o, 8'h20);

        // m1 drops and re-raises at once; m0 has been waiting and wins.
        m0_cyc_i = 1; m1_cyc_i = 0;
        tick();
        m1_cyc_i = 1;
        settle();
        check_eq("c2_idle", s_cyc_o, 0);
        tick();
        check_eq("c2_owner_m0", s_adr_o, 8'h10);

        // m0 locked for three reads while m1 strobes.
        m1_stb_i = 1; m1_we_i = 0; m0_stb_i = 1; m0_we_i = 0;
        for (int i = 0; i < 3; i++) begin
            s_ack_i = 1; s_dat_i = rd_vals[i];
            settle();
            check_eq("lock_m0_dat", m0_dat_o, rd_vals[i]);
            check_eq("lock_m0_ack", m0_ack_o, 1);
            check_eq("lock_m1_ack", m1_ack_o, 0);
            check_eq("lock_m1_dat", m1_dat_o, 0);
            tick();
        end
        s_ack_i = 0; s_dat_i = '0; m0_cyc_i = 0; m0_stb_i = 0;
        settle();
        check_eq("lock_rel_m1_ack", m1_ack_o, 0);
        tick();
        check_eq("lock_rel_idle", s_cyc_o, 0);
        tick();
        check_eq("m1_owner_cyc", s_cyc_o, 1);
        check_eq("m1_owner_adr", s_adr_o, 8'h20);

        // Timeout: slave silent, err on the 9th stb cycle with stb gated.
        for (int k = 1; k <= 8; k++) begin
            check_eq("to_wait_err", m1_err_o, 0);
            check_eq("to_wait_stb", s_stb_o, 1);
            tick();
        end
        check_eq("to_err", m1_err_o, 1);
        check_eq("to_err_stb", s_stb_o, 0);
        check_eq("to_err_m0", m0_err_o, 0);
        tick();
        check_eq("to_restart_err", m1_err_o, 0);
        check_eq("to_restart_stb", s_stb_o, 1);
        repeat (7) tick();
        // timer now at TIMEOUT_CYC-1: ack on this cycle must win.
        s_ack_i = 1; s_dat_i = 32'h5a;
        settle();
        check_eq("edge_ack", m1_ack_o, 1);
        check_eq("edge_dat", m1_dat_o, 32'h5a);
        check_eq("edge_err", m1_err_o, 0);
        tick();
        s_ack_i = 0; s_dat_i = '0;
        settle();
        check_eq("edge_no_err", m1_err_o, 0);
        check_eq("edge_stb", s_stb_o, 1);

        // Asynchronous reset in the middle of m1's read.
        #1;
        rstn = 1'b0;
        s_ack_i = 1;
        #1;
        check_eq("arst_cyc", s_cyc_o, 0);
        check_eq("arst_stb", s_stb_o, 0);
        check_eq("arst_adr", s_adr_o, 0);
        check_eq("arst_m1_ack", m1_ack_o, 0);
        s_ack_i = 0; m0_cyc_i = 1;
        tick();
        rstn = 1'b1;
        settle();
        check_eq("arst_idle", s_cyc_o, 0);
        tick();
        check_eq("arst_m0_wins", s_adr_o, 8'h10);

        // Single write by m0 after the bus goes quiet.
        m0_cyc_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        s_ack_i = 1;
        settle();
        check_eq("idle_ack_ignored", m0_ack_o, 0);
        s_ack_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 1; m0_adr_i = 8'h04;
        m0_dat_i = 32'h41; m0_sel_i = 4'hf;
        settle();
        check_eq("wr_grant_lat", s_cyc_o, 0);
        tick();
        check_eq("wr_cyc", s_cyc_o, 1);
        check_eq("wr_stb", s_stb_o, 1);
        check_eq("wr_we", s_we_o, 1);
        check_eq("wr_adr", s_adr_o, 8'h04);
        check_eq("wr_dat", s_dat_o, 32'h41);
        check_eq("wr_sel", s_sel_o, 4'hf);
        check_eq("wr_m1_dat", m1_dat_o, 0);
        check_eq("wr_wait_ack", m0_ack_o, 0);
        tick();
        check_eq("wr_wait_ack2", m0_ack_o, 0);
        tick();
        s_ack_i = 1;
        settle();
        check_eq("wr_ack", m0_ack_o, 1);
        check_eq("wr_m1_ack", m1_ack_o, 0);
        check_eq("wr_m1_err", m1_err_o, 0);
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        settle();
        check_eq("wr_ack_done", m0_ack_o, 0);
        tick();
        check_eq("wr_end_idle", s_cyc_o, 0);

        // report
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
